queue: RTL and testbench

QUEUE -- requirements
Module: queue

---
 rtl/queue_pkg.sv | 17 +
 rtl/queue_sync2.sv | 27 ++
 rtl/queue.sv | 112 +++++++++++
 tb/tb_queue.sv | 219 +++++++++++++++++++++
 4 files changed

// File: rtl/queue_pkg.sv
`default_nettype none
// ============================================================================
// Module      : queue_pkg
// Description : Shared write-FSM state type and default depth for the queue.
// Revision    : 1.0 - initial release
// ============================================================================
package queue_pkg;

    localparam int DEPTH_DEFAULT = 8;

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        ACK  = 1'b1
    } state_t;

endpackage
`default_nettype wire

// File: rtl/queue_sync2.sv
`default_nettype none
// ============================================================================
// Module      : queue_sync2
// Description : Two-flop synchronizer for a single-bit level, reset to 0.
// Revision    : 1.0 - initial release
// ============================================================================
module queue_sync2 (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic q
);

    logic meta;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta <= 1'b0;
            q    <= 1'b0;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule
`default_nettype wire

// File: rtl/queue.sv
`default_nettype none
// ============================================================================
// Module      : queue
// Description : Byte FIFO with req/ack write handshake and one-pop-per-cycle
//               read. Define QUEUE_SYNC_EN to synchronize enqueue_in.
// Revision    : 1.0 - initial release
// ============================================================================
module queue
    import queue_pkg::*;
#(
    parameter int DEPTH = DEPTH_DEFAULT
) (
    input  logic       clock_10KHZ,
    input  logic       reset,
    input  logic [7:0] data_in,
    input  logic       enqueue_in,
    output logic       ack_out,
    input  logic       dequeue_in,
    output logic [7:0] data_out,
    output logic [4:0] len_out,
    output logic       full_out,
    output logic       empty_out
);

    localparam int PTR_W = $clog2(DEPTH);

    logic             enqueue_req;
    state_t           state;
    state_t           state_next;
    logic             store;
    logic             pop;
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [4:0]       len;
    logic [7:0]       mem [DEPTH];

`ifdef QUEUE_SYNC_EN
    queue_sync2 u_enqueue_sync (
        .clk   (clock_10KHZ),
        .rst_n (reset),
        .d     (enqueue_in),
        .q     (enqueue_req)
    );
`else
    assign enqueue_req = enqueue_in;
`endif

    always_ff @(posedge clock_10KHZ or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // A request stores exactly once on entry to ACK; ACK waits for release.
    always_comb begin
        state_next = state;
        store      = 1'b0;
        case (state)
            IDLE: begin
                if (enqueue_req && !full_out) begin
                    store      = 1'b1;
                    state_next = ACK;
                end
            end
            ACK: begin
                if (!enqueue_req) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    assign ack_out   = (state == ACK);
    assign pop       = dequeue_in && !empty_out;
    assign len_out   = len;
    assign full_out  = (len == 5'(DEPTH));
    assign empty_out = (len == 5'd0);

    always_ff @(posedge clock_10KHZ) begin
        if (store) begin
            mem[wr_ptr] <= data_in;
        end
    end

    always_ff @(posedge clock_10KHZ or negedge reset) begin
        if (!reset) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            len      <= 5'd0;
            data_out <= 8'h00;
        end else begin
            if (store) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            // Read sees the pre-edge array, so a same-edge store never leaks out.
            if (pop) begin
                data_out <= mem[rd_ptr];
                rd_ptr   <= rd_ptr + 1'b1;
            end
            case ({store, pop})
                2'b10:   len <= len + 5'd1;
                2'b01:   len <= len - 5'd1;
                default: len <= len;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_queue.sv
`default_nettype none
// ============================================================================
// Module      : tb_queue
// Description : Scoreboard bench for queue: handshake, full/empty, wrap, reset.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_queue;

`ifdef QUEUE_SYNC_EN
    localparam int SYNC_LAT = 2;
`else
    localparam int SYNC_LAT = 0;
`endif
    localparam int BOUND = 20;

    logic       clk = 1'b0;
    logic       reset;
    logic [7:0] data_in;
    logic       enqueue_in;
    logic       ack_out;
    logic       dequeue_in;
    logic [7:0] data_out;
    logic [4:0] len_out;
    logic       full_out;
    logic       empty_out;

    int         vectors = 0;
    int         miscompares = 0;
    logic [7:0] sb [$];
    logic [7:0] last_pop = 8'h00;

    queue #(.DEPTH(8)) dut (
        .clock_10KHZ (clk),
        .reset       (reset),
        .data_in     (data_in),
        .enqueue_in  (enqueue_in),
        .ack_out     (ack_out),
        .dequeue_in  (dequeue_in),
        .data_out    (data_out),
        .len_out     (len_out),
        .full_out    (full_out),
        .empty_out   (empty_out)
    );

    always #50 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    task automatic step(input int n = 1);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [7:0] b);
        int n;
        data_in    = b;
        enqueue_in = 1'b1;
        n = 0;
        while (!ack_out && n < BOUND) begin
            step();
            n++;
        end
        check("accept_latency", n, SYNC_LAT + 1);
        if (ack_out) sb.push_back(b);
        enqueue_in = 1'b0;
        n = 0;
        while (ack_out && n < BOUND) begin
            step();
            n++;
        end
        check("release_latency", n, SYNC_LAT + 1);
    endtask

    task automatic pop_check(input string tag);
        dequeue_in = 1'b1;
        step();
        dequeue_in = 1'b0;
        if (sb.size() > 0) last_pop = sb.pop_front();
        check(tag, data_out, last_pop);
    endtask

    initial begin
        int n;
        reset      = 1'b0;
        data_in    = 8'h00;
        enqueue_in = 1'b0;
        dequeue_in = 1'b0;
        #20;
        check("rst_ack", ack_out, 0);
        check("rst_len", len_out, 0);
        check("rst_empty", empty_out, 1);
        check("rst_full", full_out, 0);
        check("rst_data", data_out, 8'h00);
        step(2);
        reset = 1'b1;
        step();

        // Single handshake; holding the request must not store twice.
        data_in    = 8'hA5;
        enqueue_in = 1'b1;
        step(SYNC_LAT + 1);
        check("a5_ack", ack_out, 1);
        check("a5_len", len_out, 1);
        check("a5_empty", empty_out, 0);
        step(3);
        check("a5_hold_ack", ack_out, 1);
        check("a5_hold_len", len_out, 1);
        enqueue_in = 1'b0;
        step(SYNC_LAT + 1);
        check("a5_release", ack_out, 0);
        sb.push_back(8'hA5);
        pop_check("a5_pop");
        check("a5_empty_after", empty_out, 1);

        // Fill, then a request while full must stall until a pop frees space.
        for (int i = 1; i <= 8; i++) push(8'(i));
        check("fill_full", full_out, 1);
        check("fill_len", len_out, 8);
        data_in    = 8'h09;
        enqueue_in = 1'b1;
        step(SYNC_LAT + 3);
        check("full_no_ack", ack_out, 0);
        check("full_len", len_out, 8);
        pop_check("full_pop");
        check("full_pop_ack", ack_out, 0);
        step();
        check("late_ack", ack_out, 1);
        check("late_len", len_out, 8);
        if (ack_out) sb.push_back(8'h09);
        enqueue_in = 1'b0;
        n = 0;
        while (ack_out && n < BOUND) begin
            step();
            n++;
        end
        check("late_release", ack_out, 0);

        // Drain everything, then pop once more on empty.
        for (int i = 0; i < 8; i++) pop_check("drain");
        check("drain_empty", empty_out, 1);
        dequeue_in = 1'b1;
        step();
        dequeue_in = 1'b0;
        check("empty_pop_data", data_out, last_pop);
        check("empty_pop_len", len_out, 0);

        // Simultaneous store and pop at occupancy 3.
        push(8'h31);
        push(8'h32);
        push(8'h33);
        check("three_len", len_out, 3);
        data_in    = 8'h34;
        enqueue_in = 1'b1;
        if (SYNC_LAT > 0) step(SYNC_LAT);
        dequeue_in = 1'b1;
        step();
        dequeue_in = 1'b0;
        check("both_ack", ack_out, 1);
        check("both_len", len_out, 3);
        sb.push_back(8'h34);
        last_pop = sb.pop_front();
        check("both_data", data_out, last_pop);
        enqueue_in = 1'b0;
        step(SYNC_LAT + 1);
        for (int i = 0; i < 3; i++) pop_check("both_drain");

        // Reset while in ACK with four entries.
        push(8'h41);
        push(8'h42);
        push(8'h43);
        data_in    = 8'h44;
        enqueue_in = 1'b1;
        step(SYNC_LAT + 1);
        check("pre_rst_ack", ack_out, 1);
        check("pre_rst_len", len_out, 4);
        #20;
        reset = 1'b0;
        #1;
        check("midrst_ack", ack_out, 0);
        check("midrst_len", len_out, 0);
        check("midrst_empty", empty_out, 1);
        sb.delete();
        last_pop   = 8'h00;
        data_in    = 8'h66;
        step();
        reset = 1'b1;
        step(SYNC_LAT + 1);
        check("post_rst_ack", ack_out, 1);
        check("post_rst_len", len_out, 1);
        if (ack_out) sb.push_back(8'h66);
        enqueue_in = 1'b0;
        step(SYNC_LAT + 1);
        pop_check("post_rst_pop");

        // Push/pop pairs long enough to wrap both pointers.
        for (int i = 0; i < 12; i++) begin
            push(8'hC0 + 8'(i * 5));
            pop_check("wrap_pop");
        end
        check("wrap_empty", empty_out, 1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout: simulation did not finish, expected completion");
        $fatal(1);
    end

endmodule
`default_nettype wire
